// File: rtl/mem_wb_pipe_stage_pkg.sv
// mem_wb_pkg: shared beat type, default widths and write-back select helper
package mem_wb_pkg;
   localparam int DATA_W_DEF = 64;
   localparam int RD_W_DEF   = 5;
   typedef struct packed {
      logic                  regwrite;
      logic                  memtoreg;
      logic [DATA_W_DEF-1:0] mem_data;
      logic [DATA_W_DEF-1:0] alu_data;
      logic [RD_W_DEF-1:0]   rd;
      logic [DATA_W_DEF-1:0] wb_data;
   } wb_beat_t;
   function automatic logic [DATA_W_DEF-1:0] wb_select(input logic memtoreg,
                                                       input logic [DATA_W_DEF-1:0] mem,
                                                       input logic [DATA_W_DEF-1:0] alu);
      return memtoreg ? mem : alu;
   endfunction
endpackage

// File: rtl/mem_wb_pipe_stage_if.sv
// mem_wb_pipe_stage_if: MEM-side and WB-side handshake bus of the MEM/WB stage
interface mem_wb_pipe_stage_if #(parameter int DATA_W = 64, parameter int RD_W = 5);
   logic              in_valid;
   logic              in_ready;
   logic              in_regwrite;
   logic              in_memtoreg;
   logic [DATA_W-1:0] in_mem_data;
   logic [DATA_W-1:0] in_alu_data;
   logic [RD_W-1:0]   in_rd;
   logic              out_valid;
   logic              out_ready;
   logic              out_regwrite;
   logic              out_memtoreg;
   logic [DATA_W-1:0] out_mem_data;
   logic [DATA_W-1:0] out_alu_data;
   logic [RD_W-1:0]   out_rd;
   logic [DATA_W-1:0] wb_data;
   logic              fwd_en;
   logic [RD_W-1:0]   fwd_rd;
   logic [DATA_W-1:0] fwd_data;
   modport slave (
      input  in_valid, in_regwrite, in_memtoreg, in_mem_data, in_alu_data, in_rd, out_ready,
      output in_ready, out_valid, out_regwrite, out_memtoreg, out_mem_data, out_alu_data,
             out_rd, wb_data, fwd_en, fwd_rd, fwd_data
   );
   modport master (
      output in_valid, in_regwrite, in_memtoreg, in_mem_data, in_alu_data, in_rd, out_ready,
      input  in_ready, out_valid, out_regwrite, out_memtoreg, out_mem_data, out_alu_data,
             out_rd, wb_data, fwd_en, fwd_rd, fwd_data
   );
endinterface

// File: rtl/mem_wb_pipe_stage_skid.sv
// skid_buffer_2: 2-entry FIFO-ordered valid/ready skid with registered in_ready
module skid_buffer_2 #(parameter int W = 8) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic         m_valid_q, m_valid_d, s_valid_q, s_valid_d;
   logic [W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
   logic         accept, pop, m_load, s_load;
   assign in_ready  = ~reset & ~s_valid_q;
   assign out_valid = m_valid_q;
   assign out_data  = m_data_q;
   assign accept    = in_valid & in_ready;
   assign pop       = m_valid_q & out_ready;
   assign m_load    = ~m_valid_q | pop;
   assign s_load    = accept & m_valid_q & ~pop;
   // M refills from S first so order stays FIFO; clr drops valids but keeps data
   always_comb begin
      m_valid_d = (reset | clr) ? 1'b0 : (m_load ? (s_valid_q | accept) : 1'b1);
      m_data_d  = reset ? '0 : (clr | ~m_load) ? m_data_q : s_valid_q ? s_data_q : accept ? in_data : m_data_q;
      s_valid_d = (reset | clr) ? 1'b0 : (s_valid_q ? ~pop : s_load);
      s_data_d  = reset ? '0 : (s_load & ~clr) ? in_data : s_data_q;
   end
   // entry registers
   always_ff @(posedge clk) begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
   end
endmodule

// File: rtl/mem_wb_pipe_stage.sv
// mem_wb_pipe_stage: MEM/WB register with skid buffer, x0 squash, forwarding tap and stall counter
module mem_wb_pipe_stage import mem_wb_pkg::*; #(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int RD_W      = RD_W_DEF,
   parameter int CNT_W     = 16,
   parameter int SQUASH_X0 = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   mem_wb_pipe_stage_if.slave  bus,
   output logic [CNT_W-1:0]    stall_cnt
);
   localparam int BW = 2 + 3 * DATA_W + RD_W;
   logic [BW-1:0]    beat_in, beat_out;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             out_valid;
   // capture: squash writes to x0 and resolve the write-back mux before storing
   always_comb begin
      beat_in = {bus.in_regwrite & ~((SQUASH_X0 != 0) && (bus.in_rd == '0)), bus.in_memtoreg,
                 bus.in_mem_data, bus.in_alu_data, bus.in_rd,
                 bus.in_memtoreg ? bus.in_mem_data : bus.in_alu_data};
   end
   skid_buffer_2 #(.W(BW)) u_skid (
      .clk(clk), .reset(reset), .clr(flush),
      .in_valid(bus.in_valid), .in_ready(bus.in_ready), .in_data(beat_in),
      .out_valid(out_valid), .out_ready(bus.out_ready), .out_data(beat_out)
   );
   assign {bus.out_regwrite, bus.out_memtoreg, bus.out_mem_data, bus.out_alu_data,
           bus.out_rd, bus.wb_data} = beat_out;
   assign bus.out_valid = out_valid;
   assign bus.fwd_en    = out_valid & bus.out_regwrite;
   assign bus.fwd_rd    = bus.out_rd;
   assign bus.fwd_data  = bus.wb_data;
   assign stall_cnt     = stall_cnt_q;
   // saturating count of cycles the WB side holds off a valid beat
   always_comb begin
      stall_cnt_d = reset ? '0 : (out_valid & ~bus.out_ready & ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
   end
   // stall counter register
   always_ff @(posedge clk) begin
      stall_cnt_q <= stall_cnt_d;
   end
endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// tb_mem_wb_pipe_stage: random and directed checks of two stage variants against a queue model
module tb_mem_wb_pipe_stage;
   import mem_wb_pkg::*;
   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready, in_regwrite, in_memtoreg;
   logic [63:0] in_mem, in_alu;
   logic [4:0]  in_rd;
   logic [3:0]  stall0;
   logic [15:0] stall1;
   wb_beat_t    q[$];
   int          cnt0, cnt1, errors, checks;
   mem_wb_pipe_stage_if #(.DATA_W(64), .RD_W(5)) b0 ();
   mem_wb_pipe_stage_if #(.DATA_W(64), .RD_W(5)) b1 ();
   assign b0.in_valid = in_valid;   assign b1.in_valid = in_valid;
   assign b0.in_regwrite = in_regwrite; assign b1.in_regwrite = in_regwrite;
   assign b0.in_memtoreg = in_memtoreg; assign b1.in_memtoreg = in_memtoreg;
   assign b0.in_mem_data = in_mem;  assign b1.in_mem_data = in_mem;
   assign b0.in_alu_data = in_alu;  assign b1.in_alu_data = in_alu;
   assign b0.in_rd = in_rd;         assign b1.in_rd = in_rd;
   assign b0.out_ready = out_ready; assign b1.out_ready = out_ready;
   mem_wb_pipe_stage #(.DATA_W(64), .RD_W(5), .CNT_W(4), .SQUASH_X0(1)) dut0 (
      .clk(clk), .reset(reset), .flush(flush), .bus(b0.slave), .stall_cnt(stall0));
   mem_wb_pipe_stage #(.DATA_W(64), .RD_W(5), .CNT_W(16), .SQUASH_X0(0)) dut1 (
      .clk(clk), .reset(reset), .flush(flush), .bus(b1.slave), .stall_cnt(stall1));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask
   task automatic set_beat(input logic v, input logic rw, input logic m2r,
                           input logic [63:0] mem, input logic [63:0] alu, input logic [4:0] rd);
      in_valid = v; in_regwrite = rw; in_memtoreg = m2r; in_mem = mem; in_alu = alu; in_rd = rd;
   endtask
   // check outputs against the model, clock once, then advance the model
   task automatic cycle();
      bit stalled, pop, acc;
      #1;
      chk("in_ready0", b0.in_ready, !reset && q.size() < 2);
      chk("in_ready1", b1.in_ready, !reset && q.size() < 2);
      chk("out_valid0", b0.out_valid, q.size() > 0);
      chk("out_valid1", b1.out_valid, q.size() > 0);
      if (q.size() > 0) begin
         chk("rd0", b0.out_rd, q[0].rd);
         chk("memtoreg0", b0.out_memtoreg, q[0].memtoreg);
         chk("mem0", b0.out_mem_data, q[0].mem_data);
         chk("alu0", b0.out_alu_data, q[0].alu_data);
         chk("wb0", b0.wb_data, q[0].wb_data);
         chk("regwrite0", b0.out_regwrite, q[0].regwrite && q[0].rd != 0);
         chk("fwd_en0", b0.fwd_en, q[0].regwrite && q[0].rd != 0);
         chk("fwd_rd0", b0.fwd_rd, q[0].rd);
         chk("fwd_data0", b0.fwd_data, q[0].wb_data);
         chk("regwrite1", b1.out_regwrite, q[0].regwrite);
         chk("fwd_en1", b1.fwd_en, q[0].regwrite);
         chk("wb1", b1.wb_data, q[0].wb_data);
      end else begin
         chk("fwd_en0_idle", b0.fwd_en, 0);
         chk("fwd_en1_idle", b1.fwd_en, 0);
      end
      chk("stall0", stall0, cnt0);
      chk("stall1", stall1, cnt1);
      @(posedge clk);
      if (reset) begin
         q.delete(); cnt0 = 0; cnt1 = 0;
      end else begin
         stalled = q.size() > 0 && !out_ready;
         pop = q.size() > 0 && out_ready;
         acc = in_valid && q.size() < 2;
         if (stalled && cnt0 < 15) cnt0++;
         if (stalled && cnt1 < 65535) cnt1++;
         if (pop) void'(q.pop_front());
         if (acc) q.push_back('{regwrite: in_regwrite, memtoreg: in_memtoreg, mem_data: in_mem,
                                alu_data: in_alu, rd: in_rd, wb_data: in_memtoreg ? in_mem : in_alu});
         if (flush) q.delete();
      end
      #1;
   endtask
   initial begin
      errors = 0; checks = 0; cnt0 = 0; cnt1 = 0;
      reset = 1; flush = 0; out_ready = 1;
      set_beat(1, 1, 1, 64'h55, 64'h66, 5'd3);
      @(posedge clk); #1;
      repeat (3) cycle();
      reset = 0;
      set_beat(1, 1, 1, 64'hDEAD_BEEF, 64'h1234, 5'd7);
      cycle();
      set_beat(1, 1, 0, 64'hDEAD_BEEF, 64'h1234, 5'd7);
      cycle();
      in_valid = 0;
      cycle();
      cycle();
      out_ready = 0;
      set_beat(1, 1, 1, 64'hA, 64'hA0, 5'd1); cycle();
      set_beat(1, 0, 0, 64'hB, 64'hB0, 5'd2); cycle();
      set_beat(1, 1, 0, 64'hC, 64'hC0, 5'd3); cycle(); cycle();
      out_ready = 1;
      cycle(); cycle();
      in_valid = 0;
      repeat (3) cycle();
      out_ready = 0;
      set_beat(1, 1, 1, 64'h1, 64'h2, 5'd4); cycle();
      set_beat(1, 1, 1, 64'h3, 64'h4, 5'd5); cycle();
      flush = 1;
      set_beat(1, 1, 1, 64'hD, 64'hD0, 5'd6); cycle();
      flush = 0; in_valid = 0;
      cycle();
      out_ready = 1;
      set_beat(1, 1, 1, 64'h77, 64'h88, 5'd0); cycle();
      in_valid = 0; cycle(); cycle();
      out_ready = 0;
      set_beat(1, 1, 0, 64'h9, 64'h99, 5'd9); cycle();
      in_valid = 0;
      repeat (20) cycle();
      set_beat(1, 1, 1, 64'hE, 64'hEE, 5'd10); cycle();
      in_valid = 0;
      reset = 1; cycle();
      chk("rst_mem", b0.out_mem_data, 0);
      chk("rst_alu", b0.out_alu_data, 0);
      chk("rst_wb", b0.wb_data, 0);
      chk("rst_rd", b0.out_rd, 0);
      chk("rst_regwrite", b0.out_regwrite, 0);
      chk("rst_memtoreg", b1.out_memtoreg, 0);
      reset = 0;
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(0, 49) == 0);
         flush = ($urandom_range(0, 15) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         set_beat($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom));
         cycle();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_wb_pipe_stage.md
Name: mem_wb_pipe_stage

Overview:
- Parametrised successor of the MEM/WB pipeline register.
- Carries write-back control and data from MEM to WB with a valid/ready handshake, a 2-entry skid buffer for full-throughput backpressure, synchronous flush, x0 write squashing, a registered write-back mux result, a forwarding tap and a saturating stall counter.
- Sits between the data-memory stage and the register-file write port.

Parameters:
- DATA_W, 64, width of memory read data, ALU result and write-back data.
- RD_W, 5, destination register index width.
- CNT_W, 16, width of stall performance counter.
- SQUASH_X0, 1, when 1 an entry with rd==0 is stored with regwrite=0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all held entries.
- in_valid  in  1  MEM side has a beat.
- in_ready  out  1  stage accepts a beat this cycle.
- in_regwrite  in  1  write-back enable.
- in_memtoreg  in  1  1 = select memory data, 0 = select ALU result.
- in_mem_data  in  DATA_W  data-memory read data.
- in_alu_data  in  DATA_W  ALU result.
- in_rd  in  RD_W  destination register.
- out_valid  out  1  WB side beat valid.
- out_ready  in  1  WB side consumes beat.
- out_regwrite  out  1  held write enable.
- out_memtoreg  out  1  held mux select.
- out_mem_data  out  DATA_W  held memory data.
- out_alu_data  out  DATA_W  held ALU result.
- out_rd  out  RD_W  held destination.
- wb_data  out  DATA_W  out_memtoreg ? out_mem_data : out_alu_data, computed at capture time and registered.
- fwd_en  out  1  out_valid & out_regwrite.
- fwd_rd  out  RD_W  equals out_rd.
- fwd_data  out  DATA_W  equals wb_data.
- stall_cnt  out  CNT_W  cycles with out_valid & ~out_ready, saturating.

Behaviour:
- Reset and clock:
  - One clock domain.
  - Reset is synchronous and active-high; the clock port is clk and the reset port is reset.
  - In any cycle with reset=1, next state is: both entries invalid, all held fields 0, wb_data 0, stall_cnt 0.
  - in_ready is 0 while reset=1. In the first cycle after reset deasserts, in_ready=1 and out_valid=0.
- Storage: main entry M (drives outputs) and skid entry S. Beat = {regwrite, memtoreg, mem_data, alu_data, rd, wb_data}.
- Handshake:
  - in_ready = !S.valid, a registered term with no combinational path from out_ready.
  - Accept when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - out_valid = M.valid.
  - Inputs are don't-care when in_valid=0.
- Latency: an accepted beat into an empty stage appears at the outputs the next cycle, i.e. 1 cycle. Throughput is 1 beat/cycle with out_ready held 1.
- Transitions (M.valid, S.valid):
  - Empty (0,0): accept -> M.
  - One (1,0):
    - Accept & pop -> new beat into M.
    - Accept & !pop -> beat into S.
    - Pop & !accept -> empty.
  - Full (1,1): no accept. Pop -> S moves to M, S invalid.
  - Beat order is strictly FIFO.
- Capture rules:
  - wb_data is computed from in_* at accept.
  - If SQUASH_X0=1 and in_rd==0, the stored regwrite is 0. All other fields are stored unchanged.
- Flush:
  - Next state is M.valid=0 and S.valid=0. Data fields are left unchanged.
  - A beat accepted in the flush cycle is discarded.
  - An output pop in the flush cycle is still a valid transfer on that cycle.
  - reset has priority over flush.
- Stall counter:
  - Increments by 1 each cycle with out_valid & ~out_ready.
  - Holds at 2^CNT_W-1.
  - Cleared only by reset; flush does not clear it.
- Forward tap: fwd_en=0 whenever out_valid=0.

Decomposition:
- Shared package mem_wb_pkg:
  - typedef wb_beat_t, a packed struct of the beat fields parametrised via package constants DATA_W_DEF=64, RD_W_DEF=5.
  - function wb_select(memtoreg, mem, alu).
- One sub-module is natural: skid_buffer_2, a generic 2-entry valid/ready skid holding a beat vector. It is instantiated once with width = 2+3*DATA_W+RD_W. The top level adds capture logic, the flush override and the counter.

Test Plan:
- Reset:
  - Stimulus: assert reset 3 cycles with in_valid=1, then release.
  - Required: out_valid=0, stall_cnt=0, in_ready=0 during reset and in_ready=1 in the first cycle after.
- Basic pass-through:
  - Stimulus: out_ready=1; beat regwrite=1, memtoreg=1, mem=0xDEAD_BEEF, alu=0x1234, rd=7.
  - Required: next cycle out_valid=1, wb_data=0xDEAD_BEEF, fwd_en=1, fwd_rd=7. Repeat with memtoreg=0 -> wb_data=0x1234.
- Backpressure and skid:
  - Stimulus: out_ready=0; offer beats A, B, C on consecutive cycles.
  - Required: A and B accepted, in_ready=0 while C is offered, stall_cnt increments each stalled cycle.
  - Stimulus: raise out_ready.
  - Required: A, then B, then C appear in order with no loss or duplication.
- Flush:
  - Stimulus: with M and S full, assert flush together with in_valid=1 beat D.
  - Required: next cycle out_valid=0, in_ready=1; D is never output.
- x0 squash:
  - Stimulus: beat rd=0, regwrite=1.
  - Required: out_regwrite=0 and fwd_en=0. With SQUASH_X0=0, out_regwrite=1.
- Counter saturation and mid-operation reset:
  - Stimulus: CNT_W=4; stall 20 cycles.
  - Required: stall_cnt=15 held.
  - Stimulus: then assert reset with both entries full.
  - Required: next cycle all valids=0, stall_cnt=0, outputs 0.
